relu_sequencer: RTL and testbench

RELU_SEQUENCER -- requirements
Module: relu_sequencer

---
 rtl/relu_sequencer.sv | 70 +++++++
 tb/tb_relu_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_sequencer.sv
// relu_sequencer: issues accumulator reads and steers a 2-stage ReLU/bypass pipeline into the output buffer.
module relu_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] LEN,
    input  logic       MODE_BYPASS,
    input  logic       OUT_READY,
    output logic       ACC_RD,
    output logic [7:0] ACC_ADDR,
    output logic       En_ReLU,
    output logic       En_MAC_ReLU,
    output logic       BYPASS_ReLU,
    output logic       OUT_WR,
    output logic [7:0] OUT_ADDR,
    output logic       BUSY,
    output logic       DONE
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nx;
    logic [7:0] idx, len_q, s1_addr;
    logic byp_q, s1_v, s2_v, issue, last;

    always_comb begin
        issue = state == RUN && OUT_READY;
        last = idx == len_q - 8'd1;
        state_nx = state;
        case (state)
            IDLE:    state_nx = START ? (LEN != 8'd0 ? RUN : FIN) : IDLE;
            RUN:     state_nx = issue && last ? DRAIN : RUN;
            // the pipeline is empty once the final write is in stage 2 alone
            DRAIN:   state_nx = s2_v && !s1_v ? FIN : DRAIN;
            default: state_nx = IDLE;
        endcase
        ACC_RD = issue;
        ACC_ADDR = idx;
        En_ReLU = s1_v && !byp_q;
        En_MAC_ReLU = s1_v && !byp_q;
        BYPASS_ReLU = s1_v && byp_q;
        OUT_WR = s2_v;
        BUSY = state != IDLE;
        DONE = state == FIN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx <= 8'd0;
            len_q <= 8'd0;
            byp_q <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_addr <= 8'd0;
            OUT_ADDR <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && START) begin
                idx <= 8'd0;
                len_q <= LEN;
                byp_q <= MODE_BYPASS;
            end else if (issue) begin
                idx <= idx + 8'd1;
            end
            s1_v <= issue;
            if (issue) s1_addr <= idx;
            s2_v <= s1_v;
            if (s1_v) OUT_ADDR <= s1_addr;
        end
    end
endmodule

// File: tb/tb_relu_sequencer.sv
// tb_relu_sequencer: directed checks of issue/write timing, stalls, ignored START, reset abort and LEN limits.
module tb_relu_sequencer;
    logic CLK = 1'b0, RST, START, MODE_BYPASS, OUT_READY;
    logic [7:0] LEN, ACC_ADDR, OUT_ADDR;
    logic ACC_RD, En_ReLU, En_MAC_ReLU, BYPASS_ReLU, OUT_WR, BUSY, DONE;
    int checks = 0, failures = 0;
    logic [15:0] buffer [0:3];
    logic [15:0] written [0:255];
    logic [15:0] data_reg, relu_out;

    relu_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .MODE_BYPASS(MODE_BYPASS),
        .OUT_READY(OUT_READY), .ACC_RD(ACC_RD), .ACC_ADDR(ACC_ADDR), .En_ReLU(En_ReLU),
        .En_MAC_ReLU(En_MAC_ReLU), .BYPASS_ReLU(BYPASS_ReLU), .OUT_WR(OUT_WR),
        .OUT_ADDR(OUT_ADDR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // buffer with 1-cycle read latency, ReLU stage, output buffer
    always @(posedge CLK) begin
        if (ACC_RD) data_reg <= buffer[ACC_ADDR[1:0]];
        relu_out <= (En_ReLU && data_reg[15]) ? 16'h0000 : data_reg;
        if (OUT_WR) written[OUT_ADDR] <= relu_out;
    end

    task automatic start_batch(input logic [7:0] len, input logic byp);
        START = 1'b1;
        LEN = len;
        MODE_BYPASS = byp;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic next_cycle(input int c, input logic rdy);
        if (c > 1) @(posedge CLK);
        #1 OUT_READY = rdy;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        logic [22:0] obs;
        RST = 1'b1; START = 1'b1; LEN = 8'd5; MODE_BYPASS = 1'b0; OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        obs = {ACC_RD, ACC_ADDR, En_ReLU, En_MAC_ReLU, BYPASS_ReLU, OUT_WR, OUT_ADDR, BUSY, DONE};
        checks++;
        if (obs !== 23'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        RST = 1'b0; START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_start_priority: BUSY got %b expected 0", BUSY); end
    endtask

    task automatic test_mode(input logic byp);
        logic [6:0] obs, exp;
        logic [15:0] want [0:3];
        logic rd, s1, wr;
        want = byp ? '{16'h0005, 16'h8001, 16'h7FFF, 16'hFFFF} : '{16'h0005, 16'h0000, 16'h7FFF, 16'h0000};
        start_batch(8'd4, byp);
        for (int c = 1; c <= 8; c++) begin
            next_cycle(c, 1'b1);
            rd = c >= 1 && c <= 4; s1 = c >= 2 && c <= 5; wr = c >= 3 && c <= 6;
            exp = {rd, s1 && !byp, s1 && !byp, s1 && byp, wr, c == 7, c <= 7};
            obs = {ACC_RD, En_ReLU, En_MAC_ReLU, BYPASS_ReLU, OUT_WR, DONE, BUSY};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL mode%0b_cycle%0d: got %b expected %b", byp, c, obs, exp); end
            if (rd) begin
                checks++;
                if (ACC_ADDR !== 8'(c - 1)) begin failures++; $display("FAIL mode%0b_acc_addr c%0d: got %0d expected %0d", byp, c, ACC_ADDR, c - 1); end
            end
            if (wr) begin
                checks++;
                if (OUT_ADDR !== 8'(c - 3)) begin failures++; $display("FAIL mode%0b_out_addr c%0d: got %0d expected %0d", byp, c, OUT_ADDR, c - 3); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (written[i] !== want[i]) begin failures++; $display("FAIL mode%0b_data[%0d]: got %h expected %h", byp, i, written[i], want[i]); end
        end
    endtask

    task automatic test_len_zero;
        logic [6:0] obs, exp;
        start_batch(8'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(c, 1'b1);
            exp = {5'b0, c == 1, c == 1};
            obs = {ACC_RD, En_ReLU, En_MAC_ReLU, BYPASS_ReLU, OUT_WR, DONE, BUSY};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL len0_cycle%0d: got %b expected %b", c, obs, exp); end
        end
    endtask

    task automatic test_stall;
        logic [2:0] obs, exp;
        int rds = 0, wrs = 0;
        start_batch(8'd6, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            next_cycle(c, !(c >= 3 && c <= 5));
            exp = {c inside {1, 2, 6, 7, 8, 9}, c inside {3, 4, 8, 9, 10, 11}, c == 12};
            obs = {ACC_RD, OUT_WR, DONE};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL stall_cycle%0d: got %b expected %b", c, obs, exp); end
            if (ACC_RD) begin
                checks++;
                if (ACC_ADDR !== 8'(rds)) begin failures++; $display("FAIL stall_acc_addr c%0d: got %0d expected %0d", c, ACC_ADDR, rds); end
                rds++;
            end
            if (OUT_WR) begin
                checks++;
                if (OUT_ADDR !== 8'(wrs)) begin failures++; $display("FAIL stall_out_addr c%0d: got %0d expected %0d", c, OUT_ADDR, wrs); end
                wrs++;
            end
        end
        checks++;
        if (wrs != 6) begin failures++; $display("FAIL stall_write_count: got %0d expected 6", wrs); end
        OUT_READY = 1'b1;
    endtask

    task automatic test_ignore_start;
        int wrs = 0, dones = 0, done_c = 0;
        start_batch(8'd8, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            next_cycle(c, 1'b1);
            if (c == 3) begin START = 1'b1; LEN = 8'd2; MODE_BYPASS = 1'b1; end
            if (c == 4) START = 1'b0;
            if (OUT_WR) begin
                checks++;
                if (OUT_ADDR !== 8'(wrs)) begin failures++; $display("FAIL ignore_out_addr c%0d: got %0d expected %0d", c, OUT_ADDR, wrs); end
                wrs++;
            end
            if (c >= 4 && c <= 9) begin
                checks++;
                if (BYPASS_ReLU !== 1'b0) begin failures++; $display("FAIL ignore_relatch c%0d: BYPASS_ReLU got %b expected 0", c, BYPASS_ReLU); end
            end
            if (DONE) begin dones++; done_c = c; end
        end
        checks += 3;
        if (wrs != 8) begin failures++; $display("FAIL ignore_write_count: got %0d expected 8", wrs); end
        if (dones != 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        if (done_c != 11) begin failures++; $display("FAIL ignore_done_cycle: got %0d expected 11", done_c); end
    endtask

    task automatic test_reset_abort;
        logic [22:0] obs;
        logic [3:0] o4, e4;
        start_batch(8'd8, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle(c, 1'b1);
            if (c == 4) RST = 1'b1;
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            if (c > 5) @(posedge CLK);
            @(negedge CLK);
            obs = {ACC_RD, ACC_ADDR, En_ReLU, En_MAC_ReLU, BYPASS_ReLU, OUT_WR, OUT_ADDR, BUSY, DONE};
            checks++;
            if (obs !== 23'd0) begin failures++; $display("FAIL abort_cycle%0d: got %h expected 0", c, obs); end
        end
        start_batch(8'd1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle(c, 1'b1);
            e4 = {c == 1, c == 3, c == 4, c <= 4};
            o4 = {ACC_RD, OUT_WR, DONE, BUSY};
            checks++;
            if (o4 !== e4) begin failures++; $display("FAIL after_abort_cycle%0d: got %b expected %b", c, o4, e4); end
        end
        checks++;
        if (written[0] !== 16'h0005) begin failures++; $display("FAIL after_abort_data: got %h expected 0005", written[0]); end
    endtask

    task automatic test_len_max;
        int wrs = 0, done_c = 0, last_rd = -1, bad = 0;
        start_batch(8'd255, 1'b0);
        for (int c = 1; c <= 260; c++) begin
            next_cycle(c, 1'b1);
            if (ACC_RD) last_rd = ACC_ADDR;
            if (OUT_WR) begin
                if (OUT_ADDR !== 8'(wrs)) bad++;
                wrs++;
            end
            if (DONE) done_c = c;
        end
        checks += 4;
        if (wrs != 255) begin failures++; $display("FAIL max_write_count: got %0d expected 255", wrs); end
        if (bad != 0) begin failures++; $display("FAIL max_write_order: got %0d out-of-order expected 0", bad); end
        if (last_rd != 254) begin failures++; $display("FAIL max_last_issue: got %0d expected 254", last_rd); end
        if (done_c != 258) begin failures++; $display("FAIL max_done_cycle: got %0d expected 258", done_c); end
    endtask

    initial begin
        buffer = '{16'h0005, 16'h8001, 16'h7FFF, 16'hFFFF};
        test_reset;
        test_mode(1'b0);
        test_mode(1'b1);
        test_len_zero;
        test_stall;
        test_ignore_start;
        test_reset_abort;
        test_len_max;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
